// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep capture block.
package tt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StSample,
        StFin
    } state_e;

    localparam logic [15:0] TT_601D = 16'h601D;

    function automatic int unsigned tt_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module tt_settle_timer #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_capture.sv
// Steps a gate through every input vector, samples its output after a settle
// window and compares the captured truth table with a reference.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned TT_W   = tt_width(N_IN),
    parameter int unsigned SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected_tt,
    input  logic            gate_out,
    output logic [N_IN-1:0] gate_in,
    output logic [TT_W-1:0] tt,
    output logic            busy,
    output logic            done,
    output logic            match
);

    localparam int unsigned     CntW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    // HOLD lasts SETTLE cycles and SAMPLE one more, so the timer starts one short.
    localparam logic [CntW-1:0] HoldLoad = (SETTLE > 0) ? CntW'(SETTLE - 1) : '0;
    localparam logic [N_IN-1:0] LastVec  = N_IN'(TT_W - 1);
    localparam state_e          FirstSt  = (SETTLE > 0) ? StHold : StSample;

    state_e          state_d, state_q;
    logic [N_IN-1:0] gate_in_d, gate_in_q;
    logic [TT_W-1:0] tt_d, tt_q;
    logic [TT_W-1:0] exp_d, exp_q;
    logic            busy_d, busy_q;
    logic            done_d, done_q;
    logic            match_d, match_q;
    logic            timer_load, timer_dec, timer_zero;

    tt_settle_timer #(
        .Width (CntW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (HoldLoad),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        gate_in_d  = gate_in_q;
        tt_d       = tt_q;
        exp_d      = exp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        match_d    = match_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d    = FirstSt;
                    exp_d      = expected_tt;
                    tt_d       = '0;
                    gate_in_d  = '0;
                    match_d    = 1'b0;
                    busy_d     = 1'b1;
                    timer_load = 1'b1;
                end
            end
            StHold, StSample: begin
                if (abort) begin
                    state_d   = StIdle;
                    gate_in_d = '0;
                    tt_d      = '0;
                    busy_d    = 1'b0;
                    match_d   = 1'b0;
                end else if (state_q == StHold) begin
                    if (timer_zero) begin
                        state_d = StSample;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end else begin
                    tt_d[gate_in_q] = gate_out;
                    if (gate_in_q == LastVec) begin
                        state_d   = StFin;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        gate_in_d = '0;
                        match_d   = (tt_d == exp_q);
                    end else begin
                        state_d    = FirstSt;
                        gate_in_d  = gate_in_q + 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gate_in_q <= '0;
            tt_q      <= '0;
            exp_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gate_in_q <= gate_in_d;
            tt_q      <= tt_d;
            exp_q     <= exp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            match_q   <= match_d;
        end
    end

    assign gate_in = gate_in_q;
    assign tt      = tt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign match   = match_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench: default build against a 0x601D gate model, plus a SETTLE=0 build.
module tb_tt_sweep_capture;
    import tt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [15:0] expected_tt;
    logic [15:0] model_tt;
    logic        gate_out;
    logic [3:0]  gate_in;
    logic [15:0] tt;
    logic        busy, done, match;

    logic        start0;
    logic [15:0] expected_tt0;
    logic        gate_out0;
    logic [3:0]  gate_in0;
    logic [15:0] tt0;
    logic        busy0, done0, match0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign gate_out = model_tt[gate_in];

    tt_sweep_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .expected_tt (expected_tt),
        .gate_out    (gate_out),
        .gate_in     (gate_in),
        .tt          (tt),
        .busy        (busy),
        .done        (done),
        .match       (match)
    );

    tt_sweep_capture #(
        .SETTLE (0)
    ) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start0),
        .abort       (1'b0),
        .expected_tt (expected_tt0),
        .gate_out    (gate_out0),
        .gate_in     (gate_in0),
        .tt          (tt0),
        .busy        (busy0),
        .done        (done0),
        .match       (match0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] e);
        expected_tt = e;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called just after the start edge; returns just after edge start+48.
    task automatic run_to_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int j = 1; j < 48; j++) begin
            tick();
            seen |= done;
        end
        chk({tag, "_no_early_done"}, 32'(seen), 32'd0);
        tick();
        chk({tag, "_done_at_48"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic seen;
        rst_n        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        expected_tt  = '0;
        model_tt     = TT_601D;
        start0       = 1'b0;
        expected_tt0 = '0;
        gate_out0    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {gate_in, tt, busy, done, match}, 32'd0);
        chk("reset_outputs0", {gate_in0, tt0, busy0, done0, match0}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Sweep A: matching reference, cycle-by-cycle vector timing
        pulse_start(TT_601D);
        for (int j = 0; j < 48; j++) begin
            chk("a_step_busy_done_gate_in", {busy, done, gate_in}, {1'b1, 1'b0, 4'(j / 3)});
            tick();
        end
        chk("a_done", 32'(done), 32'd1);
        chk("a_busy_low", 32'(busy), 32'd0);
        chk("a_gate_in_zero", 32'(gate_in), 32'd0);
        chk("a_tt", 32'(tt), 32'h601D);
        chk("a_match", 32'(match), 32'd1);
        abort = 1'b1;  // abort during FIN must be ignored
        tick();
        abort = 1'b0;
        chk("a_done_one_cycle", 32'(done), 32'd0);
        chk("a_tt_held_after_fin_abort", 32'(tt), 32'h601D);
        chk("a_match_held_after_fin_abort", 32'(match), 32'd1);

        // start together with abort in IDLE: nothing happens
        expected_tt = 16'h0000;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("idle_start_abort_busy", 32'(busy), 32'd0);
        chk("idle_start_abort_tt", 32'(tt), 32'h601D);
        chk("idle_start_abort_match", 32'(match), 32'd1);

        // Sweep B: mismatching reference
        pulse_start(16'h601C);
        chk("b_match_cleared", 32'(match), 32'd0);
        run_to_done("b");
        chk("b_tt", 32'(tt), 32'h601D);
        chk("b_match", 32'(match), 32'd0);
        tick();

        // start re-pulsed at cycles 5 and 20 with a different reference
        pulse_start(TT_601D);
        repeat (4) tick();
        expected_tt = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_gate_in_at_20", 32'(gate_in), 32'd6);
        seen = 1'b0;
        for (int j = 21; j < 48; j++) begin
            tick();
            seen |= done;
        end
        chk("restart_no_early_done", 32'(seen), 32'd0);
        tick();
        chk("restart_done_at_48", 32'(done), 32'd1);
        chk("restart_tt", 32'(tt), 32'h601D);
        chk("restart_match_first_ref", 32'(match), 32'd1);
        tick();

        // abort at cycle 10
        pulse_start(TT_601D);
        repeat (9) tick();
        chk("abort_partial_tt", 32'(tt), 32'h5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outputs", {gate_in, tt, busy, done, match}, 32'd0);
        seen = 1'b0;
        for (int j = 0; j < 50; j++) begin
            tick();
            seen |= done | busy;
        end
        chk("abort_stays_idle", 32'(seen), 32'd0);
        pulse_start(TT_601D);
        run_to_done("after_abort");
        chk("after_abort_tt", 32'(tt), 32'h601D);
        chk("after_abort_match", 32'(match), 32'd1);
        tick();

        // reset at cycle 30
        pulse_start(TT_601D);
        repeat (29) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {gate_in, tt, busy, done, match}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 50; j++) begin
            tick();
            seen |= done | busy;
        end
        chk("reset_no_done", 32'(seen), 32'd0);
        pulse_start(TT_601D);
        run_to_done("after_reset");
        chk("after_reset_tt", 32'(tt), 32'h601D);
        chk("after_reset_match", 32'(match), 32'd1);
        tick();

        // SETTLE=0 build: one cycle per vector, constant gates
        gate_out0    = 1'b1;
        expected_tt0 = 16'hFFFF;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int j = 0; j < 16; j++) begin
            chk("s0_step_busy_done_gate_in", {busy0, done0, gate_in0}, {1'b1, 1'b0, 4'(j)});
            tick();
        end
        chk("s0_one_done_at_16", 32'(done0), 32'd1);
        chk("s0_one_tt", 32'(tt0), 32'hFFFF);
        chk("s0_one_match", 32'(match0), 32'd1);
        tick();
        gate_out0 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (15) tick();
        chk("s0_zero_not_yet_done", 32'(done0), 32'd0);
        tick();
        chk("s0_zero_done_at_16", 32'(done0), 32'd1);
        chk("s0_zero_tt", 32'(tt0), 32'h0000);
        chk("s0_zero_match", 32'(match0), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential truth-table reader for the single-output 4-input combinational gate netlists produced by the synthesis flow.
- On start, drives every input vector 0..2^N_IN-1 onto the gate under test, waits a programmable settle time, and samples the gate output into a truth-table word.
- Compares the captured word with an expected hex truth table, for example 0x601D.
- Sits beside each generated gate in the characterisation harness; it is the reading end of the gate's input/output interface.

Parameters:
- N_IN, 4: number of gate inputs. Legal range 1..6.
- TT_W, 2**N_IN: truth-table width. Derived; must not be overridden.
- SETTLE, 2: extra cycles each vector is held before sampling. Legal range 0..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep. Honoured only in IDLE.
- abort  in  1  cancels a sweep in progress.
- expected_tt  in  TT_W  reference truth table. Sampled on the accepted start.
- gate_out  in  1  output of the gate under test.
- gate_in  out  N_IN  input vector driven to the gate. gate_in[0] is the gate's first input.
- tt  out  TT_W  captured truth table. tt[v] = gate_out while gate_in == v.
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse when a sweep completes.
- match  out  1  (tt == expected_tt). Valid from done; held until the next accepted start.

Behaviour:
- Reset: every output is 0 (gate_in, tt, busy, done, match). The FSM enters IDLE and internal counters clear. Reset asserted mid-sweep abandons the sweep with no done pulse.
- FSM states:
  - IDLE
  - HOLD: gate_in stable, settle counter running.
  - SAMPLE: edge on which gate_out is captured.
  - FIN
- IDLE → HOLD, when start=1 and abort=0:
  - latch expected_tt;
  - set tt=0, gate_in=0, settle counter=SETTLE, match=0;
  - set busy=1 from the next cycle.
- HOLD: decrement the counter each cycle. Move to SAMPLE when the counter is 0 (SETTLE=0 gives zero HOLD cycles).
- SAMPLE:
  - tt[gate_in] <= gate_out.
  - If gate_in == TT_W-1, go to FIN.
  - Otherwise gate_in <= gate_in+1, reload the counter, go to HOLD.
- Timing: each vector is applied for exactly SETTLE+1 cycles, and the sample is taken on the last edge of that window.
- FIN (one cycle): done=1, match <= (tt == latched expected), busy=0, gate_in <= 0, return to IDLE.
- Latency: done is high in the cycle after edge (start edge + TT_W*(SETTLE+1)). With defaults that is 48 cycles after the start edge.
- Index width: the vector index is N_IN bits. The comparison with TT_W-1 is exact and no wrap-around is permitted: the index never increments past TT_W-1.
- start while busy: ignored. It does not restart the sweep or re-latch expected_tt.
- abort while busy: return to IDLE next cycle with gate_in=0, busy=0, done=0, tt cleared to 0, match=0. abort in IDLE has no effect.
- abort and start together in IDLE: abort wins and no sweep starts.
- abort on the FIN cycle: ignored; done still pulses.
- tt and match hold their values in IDLE until the next accepted start or abort.
- gate_out is treated as combinational from gate_in on the same clock. Any metastability handling belongs to the harness.

Decomposition:
- Shared package tt_pkg holds:
  - the state enum (IDLE, HOLD, SAMPLE, FIN);
  - a function tt_width(n) returning 2**n;
  - constant TT_601D = 16'h601D for the default benches.
- One natural sub-module, tt_settle_timer: loadable down-counter with a zero flag, width $clog2(SETTLE+1) with a minimum of 1. The FSM, index register and capture register stay in the top.

Test Plan:
- Gate model 0x601D, expected_tt=0x601D, SETTLE=2, pulse start → done exactly 48 cycles later; tt=0x601D, match=1; busy high for 48 cycles; gate_in steps 0..15, each value held 3 cycles.
- Same sweep with expected_tt=0x601C → tt=0x601D, match=0; done still at cycle 48.
- SETTLE=0 build, constant-1 gate → tt=0xFFFF, done 16 cycles after start. Constant-0 gate → tt=0x0000.
- start re-pulsed at cycles 5 and 20 of a sweep → no restart; done still at cycle 48; expected_tt latched at the first start is used.
- abort at cycle 10 → idle next cycle: busy=0, gate_in=0, tt=0, no done. A following start completes a full sweep normally.
- rst_n low at cycle 30 → all outputs 0 asynchronously and no done. After rst_n rises, start then produces a full correct sweep.
